// File: rtl/btb_assoc.sv
// Fully associative branch target buffer with 2-bit saturating direction
// counters and true-LRU replacement kept as a per-entry age permutation.
module btb_assoc #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W_PC  = 32,
  parameter int unsigned W_BTA = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W_PC-1:0]  pc,
  output logic             hit,
  output logic             pred_taken,
  output logic [W_BTA-1:0] bta,
  input  logic             upd_valid,
  input  logic [W_PC-1:0]  upd_pc,
  input  logic [W_BTA-1:0] upd_target,
  input  logic             upd_taken,
  input  logic             flush
);

  localparam int unsigned W_TAG = W_PC - 2;
  localparam int unsigned W_AGE = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [DEPTH-1:0][W_TAG-1:0]   tag_q,   tag_d;
  logic [DEPTH-1:0][W_BTA-1:0]   tgt_q,   tgt_d;
  logic [DEPTH-1:0][1:0]         ctr_q,   ctr_d;
  logic [DEPTH-1:0][W_AGE-1:0]   age_q,   age_d;

  logic [W_TAG-1:0] look_tag;
  logic [W_TAG-1:0] upd_tag;
  logic [W_AGE-1:0] hit_idx;
  logic             upd_hit;
  logic [W_AGE-1:0] upd_idx;
  logic             inv_found;
  logic [W_AGE-1:0] inv_idx;
  logic [W_AGE-1:0] lru_idx;
  logic             touch;
  logic [W_AGE-1:0] touch_idx;
  logic [W_AGE-1:0] alloc_idx;
  logic             unused_bits;

  assign look_tag    = pc[W_PC-1:2];
  assign upd_tag     = upd_pc[W_PC-1:2];
  assign unused_bits = ^{pc[1:0], upd_pc[1:0]};

  // Lookup: reversed scans so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == look_tag)) begin
        hit     = 1'b1;
        hit_idx = W_AGE'(i);
      end
    end
    pred_taken = hit & ctr_q[hit_idx][1];
    bta        = hit ? tgt_q[hit_idx] : '0;
  end

  // Update-side searches: matching entry, first free slot, and LRU victim.
  always_comb begin
    upd_hit   = 1'b0;
    upd_idx   = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    lru_idx   = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == upd_tag)) begin
        upd_hit = 1'b1;
        upd_idx = W_AGE'(i);
      end
      if (!valid_q[i]) begin
        inv_found = 1'b1;
        inv_idx   = W_AGE'(i);
      end
      if (age_q[i] == W_AGE'(DEPTH - 1)) begin
        lru_idx = W_AGE'(i);
      end
    end
  end

  // Next state: flush beats update; a miss with not-taken leaves everything alone.
  always_comb begin
    valid_d   = valid_q;
    tag_d     = tag_q;
    tgt_d     = tgt_q;
    ctr_d     = ctr_q;
    age_d     = age_q;
    touch     = 1'b0;
    touch_idx = '0;
    alloc_idx = inv_found ? inv_idx : lru_idx;

    if (flush) begin
      valid_d = '0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          ctr_d[upd_idx] = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
          tgt_d[upd_idx] = upd_target;
        end else begin
          ctr_d[upd_idx] = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
        end
        touch     = 1'b1;
        touch_idx = upd_idx;
      end else if (upd_taken) begin
        valid_d[alloc_idx] = 1'b1;
        tag_d[alloc_idx]   = upd_tag;
        tgt_d[alloc_idx]   = upd_target;
        ctr_d[alloc_idx]   = 2'b10;
        touch              = 1'b1;
        touch_idx          = alloc_idx;
      end
    end

    if (touch) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (age_q[i] < age_q[touch_idx]) begin
          age_d[i] = age_q[i] + W_AGE'(1);
        end
      end
      age_d[touch_idx] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ctr_q[i] <= 2'b01;
        age_q[i] <= W_AGE'(i);
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
      age_q   <= age_d;
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc: directed scenarios plus a randomized run against a
// behavioural model that tracks recency as an MRU-first ordering list.
module tb_btb_assoc;

  localparam int DEPTH = 4;
  localparam int W_PC  = 32;
  localparam int W_BTA = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [W_PC-1:0]  pc;
  logic             hit;
  logic             pred_taken;
  logic [W_BTA-1:0] bta;
  logic             upd_valid;
  logic [W_PC-1:0]  upd_pc;
  logic [W_BTA-1:0] upd_target;
  logic             upd_taken;
  logic             flush;

  int n_cmp = 0;
  int n_err = 0;

  bit               m_valid [DEPTH];
  logic [W_PC-3:0]  m_tag   [DEPTH];
  logic [W_BTA-1:0] m_tgt   [DEPTH];
  int               m_ctr   [DEPTH];
  int               order   [$];

  always #5 clk = ~clk;

  btb_assoc #(.DEPTH(DEPTH), .W_PC(W_PC), .W_BTA(W_BTA)) dut (
    .clk(clk), .reset(reset), .pc(pc), .hit(hit), .pred_taken(pred_taken),
    .bta(bta), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .flush(flush)
  );

  task automatic model_reset();
    order = {};
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
      order.push_back(i);
    end
  endtask

  task automatic model_touch(input int k);
    int pos;
    pos = -1;
    for (int i = 0; i < order.size(); i++) if (order[i] == k) pos = i;
    if (pos >= 0) order.delete(pos);
    order.push_front(k);
  endtask

  task automatic model_update();
    int k;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      return;
    end
    if (!upd_valid) return;
    k = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (m_valid[i] && m_tag[i] == upd_pc[W_PC-1:2]) k = i;
    if (k >= 0) begin
      if (upd_taken) begin
        if (m_ctr[k] < 3) m_ctr[k]++;
        m_tgt[k] = upd_target;
      end else if (m_ctr[k] > 0) begin
        m_ctr[k]--;
      end
      model_touch(k);
    end else if (upd_taken) begin
      for (int i = DEPTH - 1; i >= 0; i--) if (!m_valid[i]) k = i;
      if (k < 0) k = order[$];
      m_valid[k] = 1'b1;
      m_tag[k]   = upd_pc[W_PC-1:2];
      m_tgt[k]   = upd_target;
      m_ctr[k]   = 2;
      model_touch(k);
    end
  endtask

  task automatic model_lookup(input logic [W_PC-1:0] a, output logic e_hit,
                              output logic e_pred, output logic [W_BTA-1:0] e_bta);
    int k;
    k = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (m_valid[i] && m_tag[i] == a[W_PC-1:2]) k = i;
    e_hit  = (k >= 0);
    e_pred = (k >= 0) && (m_ctr[k] >= 2);
    e_bta  = (k >= 0) ? m_tgt[k] : '0;
  endtask

  // Advance one clock; the model commits the inputs sampled at that edge.
  task automatic cycle();
    @(posedge clk);
    if (reset) model_update();
    #1;
  endtask

  task automatic idle();
    upd_valid = 1'b0; upd_taken = 1'b0; upd_pc = '0; upd_target = '0; flush = 1'b0;
  endtask

  task automatic set_upd(input logic [W_PC-1:0] a, input logic [W_BTA-1:0] t, input logic tk);
    upd_valid = 1'b1; upd_pc = a; upd_target = t; upd_taken = tk;
  endtask

  task automatic do_reset();
    idle();
    pc = '0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    model_reset();
    pc = 32'h100;
    #3;
    n_cmp++;
    if ({hit, pred_taken, bta} !== {1'b0, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_outputs: got hit=%b pred=%b bta=%h, want 0/0/0", hit, pred_taken, bta);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    cycle();
    n_cmp++;
    if ({hit, pred_taken, bta} !== {1'b0, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL post_reset_lookup: got hit=%b pred=%b bta=%h, want 0/0/0", hit, pred_taken, bta);
    end
  endtask

  task automatic test_counter();
    do_reset();
    pc = 32'h100;
    set_upd(32'h100, 32'h2000, 1'b1);
    cycle();
    idle();
    #1;
    n_cmp++;
    if ({hit, pred_taken, bta} !== {1'b1, 1'b1, 32'h2000}) begin
      n_err++;
      $display("FAIL alloc_lookup: got hit=%b pred=%b bta=%h, want 1/1/2000", hit, pred_taken, bta);
    end
    // Same-cycle lookup must still see the counter before this update commits.
    set_upd(32'h100, 32'h3000, 1'b0);
    #1;
    n_cmp++;
    if (pred_taken !== 1'b1) begin
      n_err++;
      $display("FAIL no_bypass: got pred=%b, want 1", pred_taken);
    end
    cycle();
    idle();
    #1;
    n_cmp++;
    if ({hit, pred_taken, bta} !== {1'b1, 1'b0, 32'h2000}) begin
      n_err++;
      $display("FAIL ctr_2to1: got hit=%b pred=%b bta=%h, want 1/0/2000", hit, pred_taken, bta);
    end
    repeat (2) begin
      set_upd(32'h100, 32'h3000, 1'b0);
      cycle();
    end
    // Counter must sit at 0; one taken step then lands on 1, still not-taken.
    set_upd(32'h100, 32'h2000, 1'b1);
    cycle();
    idle();
    #1;
    n_cmp++;
    if ({hit, pred_taken, bta} !== {1'b1, 1'b0, 32'h2000}) begin
      n_err++;
      $display("FAIL ctr_sat_low: got hit=%b pred=%b bta=%h, want 1/0/2000", hit, pred_taken, bta);
    end
    repeat (4) begin
      set_upd(32'h100, 32'h2400, 1'b1);
      cycle();
    end
    set_upd(32'h100, 32'h2800, 1'b0);
    cycle();
    idle();
    #1;
    n_cmp++;
    if ({hit, pred_taken, bta} !== {1'b1, 1'b1, 32'h2400}) begin
      n_err++;
      $display("FAIL ctr_sat_high: got hit=%b pred=%b bta=%h, want 1/1/2400", hit, pred_taken, bta);
    end
  endtask

  task automatic test_eviction();
    logic [W_PC-1:0]  addrs [6];
    logic             want_hit [6];
    addrs    = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114};
    want_hit = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_upd(addrs[i], 32'h1000 + addrs[i], 1'b1);
      cycle();
    end
    set_upd(32'h100, 32'h1100, 1'b1);
    cycle();
    set_upd(32'h110, 32'h1110, 1'b1);
    cycle();
    idle();
    for (int i = 0; i < 6; i++) begin
      pc = addrs[i];
      #1;
      n_cmp++;
      if (hit !== want_hit[i] || bta !== (want_hit[i] ? 32'h1000 + addrs[i] : 32'h0)) begin
        n_err++;
        $display("FAIL evict_%h: got hit=%b bta=%h, want hit=%b", addrs[i], hit, bta, want_hit[i]);
      end
    end
  endtask

  task automatic test_flush();
    logic [W_PC-1:0] probe [3];
    probe = '{32'h100, 32'h108, 32'h200};
    flush = 1'b1;
    set_upd(32'h200, 32'h5000, 1'b1);
    cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      pc = probe[i];
      #1;
      n_cmp++;
      if ({hit, pred_taken, bta} !== {1'b0, 1'b0, 32'h0}) begin
        n_err++;
        $display("FAIL flush_%h: got hit=%b pred=%b bta=%h, want 0/0/0", probe[i], hit, pred_taken, bta);
      end
    end
    set_upd(32'h300, 32'h6000, 1'b1);
    cycle();
    idle();
    pc = 32'h300;
    #1;
    n_cmp++;
    if ({hit, pred_taken, bta} !== {1'b1, 1'b1, 32'h6000}) begin
      n_err++;
      $display("FAIL post_flush_alloc: got hit=%b pred=%b bta=%h, want 1/1/6000", hit, pred_taken, bta);
    end
  endtask

  task automatic test_reset_mid_update();
    pc = 32'h300;
    set_upd(32'h400, 32'h7000, 1'b1);
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({hit, pred_taken, bta} !== {1'b0, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL async_reset: got hit=%b pred=%b bta=%h, want 0/0/0", hit, pred_taken, bta);
    end
    cycle();
    idle();
    #2 reset = 1'b1;
    pc = 32'h400;
    #1;
    n_cmp++;
    if (hit !== 1'b0) begin
      n_err++;
      $display("FAIL discarded_update: got hit=%b, want 0", hit);
    end
    cycle();
  endtask

  task automatic test_random();
    logic             e_hit, e_pred;
    logic [W_BTA-1:0] e_bta;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      pc         = 32'h100 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      upd_valid  = ($urandom_range(0, 3) != 0);
      upd_pc     = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      upd_target = $urandom;
      upd_taken  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 39) == 0);
      #1;
      model_lookup(pc, e_hit, e_pred, e_bta);
      n_cmp++;
      if (hit !== e_hit || pred_taken !== e_pred || bta !== e_bta) begin
        n_err++;
        $display("FAIL random_%0d pc=%h: got %b/%b/%h, want %b/%b/%h",
                 n, pc, hit, pred_taken, bta, e_hit, e_pred, e_bta);
      end
      cycle();
    end
    idle();
  endtask

  initial begin
    idle();
    pc = '0;
    reset = 1'b0;
    test_reset();
    test_counter();
    test_eviction();
    test_flush();
    test_reset_mid_update();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
